// File: rtl/f3_move_sched.sv
// Move scheduler: turns held direction keys into single board moves and,
// on a scramble request, issues a pseudo-random burst of moves that never
// immediately undoes the previous move.
module f3_move_sched #(
    parameter logic [7:0]  SCRAMBLE_MOVES = 8'd64,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       key_write,
    input  logic [3:0] key_instruction,
    input  logic       scramble,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [3:0] move_dir,
    output logic       busy,
    output logic [7:0] moves_left
);

    typedef enum logic [2:0] {
        IDLE, USER_MOVE, RELEASE, SCRAMBLE, SCR_GAP, SCR_HOLD
    } state_t;

    // An all-zero seed would lock the LFSR, so it is forced to 1.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] TAPS = 16'hB400;

    state_t      state, state_nxt;
    logic [3:0]  user_dir;
    logic [3:0]  last_dir;
    logic [15:0] lfsr;
    logic [7:0]  cnt;
    logic        scramble_prev;
    logic        scr_edge;
    logic        key_ok;
    logic        xfer;
    logic [3:0]  cand;
    logic [3:0]  alt;
    logic [3:0]  scr_dir;

    assign scr_edge = scramble & ~scramble_prev;
    assign key_ok   = key_write && (key_instruction >= 4'd1) && (key_instruction <= 4'd4);
    assign xfer     = move_valid & move_ready;

    // Random direction 1..4; opposite pairs sum to 5, so a reversal of the
    // previous move is bumped to the next code in the 1->2->3->4->1 ring.
    assign cand    = {2'b00, lfsr[1:0]} + 4'd1;
    assign alt     = {2'b00, lfsr[1:0] + 2'd1} + 4'd1;
    assign scr_dir = ((cand + last_dir) == 4'd5) ? alt : cand;

    assign move_dir   = (state == SCRAMBLE) ? scr_dir : user_dir;
    assign moves_left = cnt;

    // State register.
    always_ff @(posedge sysclk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and per-state outputs.
    always_comb begin
        state_nxt  = state;
        move_valid = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (scr_edge)
                    state_nxt = (SCRAMBLE_MOVES != 8'd0) ? SCRAMBLE : SCR_HOLD;
                else if (key_ok)
                    state_nxt = USER_MOVE;
            end
            USER_MOVE: begin
                move_valid = 1'b1;
                if (move_ready) state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!key_write) state_nxt = IDLE;
            end
            SCRAMBLE: begin
                move_valid = 1'b1;
                busy       = 1'b1;
                if (move_ready) state_nxt = (cnt == 8'd1) ? SCR_HOLD : SCR_GAP;
            end
            SCR_GAP: begin
                busy      = 1'b1;
                state_nxt = SCRAMBLE;
            end
            SCR_HOLD: begin
                busy = 1'b1;
                if (!scramble) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: key latch, last direction, scramble counter and LFSR.
    // scramble_prev resets high so a request held through reset is not an edge.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            user_dir      <= 4'd0;
            last_dir      <= 4'd0;
            lfsr          <= SEED;
            cnt           <= 8'd0;
            scramble_prev <= 1'b1;
        end else begin
            scramble_prev <= scramble;
            if (state == IDLE && !scr_edge && key_ok)
                user_dir <= key_instruction;
            if (xfer)
                last_dir <= move_dir;
            if (state == IDLE && scr_edge)
                cnt <= SCRAMBLE_MOVES;
            if (state == SCRAMBLE && move_ready) begin
                cnt  <= cnt - 8'd1;
                lfsr <= lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
            end
        end
    end

endmodule

// File: tb/tb_f3_move_sched.sv
// Directed bench for f3_move_sched: key presses, backpressure, scramble
// sequencing, hold-off, anti-reversal and reset mid-scramble.
module tb_f3_move_sched;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       key_write;
    logic [3:0] key_instruction;
    logic       scramble;
    logic       move_ready;
    logic       move_valid;
    logic [3:0] move_dir;
    logic       busy;
    logic [7:0] moves_left;

    // Second instance with a seed whose first draw is a reversal of North.
    logic       b_key_write;
    logic [3:0] b_key_instruction;
    logic       b_scramble;
    logic       b_move_ready;
    logic       b_move_valid;
    logic [3:0] b_move_dir;
    logic       b_busy;
    logic [7:0] b_moves_left;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    f3_move_sched dut (
        .sysclk(sysclk), .reset(reset), .key_write(key_write),
        .key_instruction(key_instruction), .scramble(scramble),
        .move_ready(move_ready), .move_valid(move_valid), .move_dir(move_dir),
        .busy(busy), .moves_left(moves_left)
    );

    f3_move_sched #(.SCRAMBLE_MOVES(8'd2), .LFSR_SEED(16'h0003)) dut_b (
        .sysclk(sysclk), .reset(reset), .key_write(b_key_write),
        .key_instruction(b_key_instruction), .scramble(b_scramble),
        .move_ready(b_move_ready), .move_valid(b_move_valid), .move_dir(b_move_dir),
        .busy(b_busy), .moves_left(b_moves_left)
    );

    always #5 sysclk = ~sysclk;

    // Count transfers on the main instance.
    always @(posedge sysclk) begin
        if (!reset && move_valid && move_ready) xfers <= xfers + 1;
    end

    task automatic tick;
        @(posedge sysclk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", move_valid); end
        checks++; if (move_dir !== 4'd0) begin errors++; $display("FAIL reset_dir got %0d want 0", move_dir); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d want 0", busy); end
        checks++; if (moves_left !== 8'd0) begin errors++; $display("FAIL reset_moves_left got %0d want 0", moves_left); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_key_press;
        int base;
        int extra;
        base = xfers;
        move_ready = 1'b1;
        key_instruction = 4'd3;
        key_write = 1'b1;
        tick;
        checks++; if (move_valid !== 1'b1) begin errors++; $display("FAIL key_valid got %0d want 1", move_valid); end
        checks++; if (move_dir !== 4'd3) begin errors++; $display("FAIL key_dir got %0d want 3", move_dir); end
        tick;
        checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL key_one_cycle got %0d want 0", move_valid); end
        extra = 0;
        repeat (4) begin tick; if (move_valid) extra++; end
        checks++; if (extra != 0) begin errors++; $display("FAIL key_held_repeat got %0d want 0", extra); end
        checks++; if (xfers - base != 1) begin errors++; $display("FAIL key_transfers got %0d want 1", xfers - base); end
        key_write = 1'b0;
        tick;
        key_write = 1'b1;
        tick;
        checks++; if (move_valid !== 1'b1 || move_dir !== 4'd3) begin
            errors++; $display("FAIL key_repress got valid=%0d dir=%0d want 1/3", move_valid, move_dir); end
        key_write = 1'b0;
        tick;
        tick;
        // Invalid codes are ignored.
        extra = 0;
        key_write = 1'b1;
        key_instruction = 4'd5;
        repeat (3) begin tick; if (move_valid) extra++; end
        key_instruction = 4'd0;
        repeat (3) begin tick; if (move_valid) extra++; end
        checks++; if (extra != 0) begin errors++; $display("FAIL key_invalid got %0d want 0", extra); end
        key_write = 1'b0;
        tick;
    endtask

    task automatic test_backpressure;
        int base;
        int bad;
        base = xfers;
        bad = 0;
        move_ready = 1'b0;
        key_instruction = 4'd2;
        key_write = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick;
            if (move_valid !== 1'b1 || move_dir !== 4'd2) bad++;
            move_ready = (k == 6);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
        tick;
        checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL bp_after got %0d want 0", move_valid); end
        checks++; if (xfers - base != 1) begin errors++; $display("FAIL bp_transfers got %0d want 1", xfers - base); end
        key_write = 1'b0;
        tick;
    endtask

    task automatic test_anti_reversal;
        b_move_ready = 1'b1;
        b_key_instruction = 4'd1;
        b_key_write = 1'b1;
        tick;
        checks++; if (b_move_valid !== 1'b1 || b_move_dir !== 4'd1) begin
            errors++; $display("FAIL ar_user got valid=%0d dir=%0d want 1/1", b_move_valid, b_move_dir); end
        tick;
        b_key_write = 1'b0;
        tick;
        b_scramble = 1'b1;
        tick;
        checks++; if (b_move_valid !== 1'b1 || b_move_dir !== 4'd1) begin
            errors++; $display("FAIL ar_first got valid=%0d dir=%0d want 1/1", b_move_valid, b_move_dir); end
        checks++; if (b_moves_left !== 8'd2) begin errors++; $display("FAIL ar_ml got %0d want 2", b_moves_left); end
        tick;
        checks++; if (b_move_valid !== 1'b0 || b_busy !== 1'b1) begin
            errors++; $display("FAIL ar_gap got valid=%0d busy=%0d want 0/1", b_move_valid, b_busy); end
        tick;
        checks++; if (b_move_valid !== 1'b1 || b_move_dir !== 4'd2 || b_moves_left !== 8'd1) begin
            errors++; $display("FAIL ar_second got valid=%0d dir=%0d ml=%0d want 1/2/1", b_move_valid, b_move_dir, b_moves_left); end
        tick;
        checks++; if (b_move_valid !== 1'b0 || b_busy !== 1'b1 || b_moves_left !== 8'd0) begin
            errors++; $display("FAIL ar_hold got valid=%0d busy=%0d ml=%0d want 0/1/0", b_move_valid, b_busy, b_moves_left); end
        b_scramble = 1'b0;
        tick;
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL ar_idle got busy=%0d want 0", b_busy); end
    endtask

    task automatic test_scramble;
        int n, gap_run, bad_gap, bad_ml, cyc;
        logic [3:0] d [3];
        n = 0; gap_run = 0; bad_gap = 0; bad_ml = 0; cyc = 0;
        d[0] = 4'd0; d[1] = 4'd0; d[2] = 4'd0;
        move_ready = 1'b1;
        scramble = 1'b1;
        while (n < 64 && cyc < 400) begin
            tick;
            cyc++;
            if (move_valid) begin
                if (n < 3) d[n] = move_dir;
                if (moves_left !== 8'(64 - n)) bad_ml++;
                if (n > 0 && gap_run != 1) bad_gap++;
                n++;
                gap_run = 0;
            end else begin
                gap_run++;
            end
        end
        checks++; if (n != 64) begin errors++; $display("FAIL scr_count got %0d want 64", n); end
        checks++; if (d[0] !== 4'd2) begin errors++; $display("FAIL scr_dir0 got %0d want 2", d[0]); end
        checks++; if (d[1] !== 4'd1) begin errors++; $display("FAIL scr_dir1 got %0d want 1", d[1]); end
        checks++; if (d[2] !== 4'd1) begin errors++; $display("FAIL scr_dir2 got %0d want 1", d[2]); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL scr_gap got %0d bad gaps want 0", bad_gap); end
        checks++; if (bad_ml != 0) begin errors++; $display("FAIL scr_moves_left got %0d bad values want 0", bad_ml); end
        tick;
        checks++; if (move_valid !== 1'b0 || busy !== 1'b1 || moves_left !== 8'd0) begin
            errors++; $display("FAIL scr_end got valid=%0d busy=%0d ml=%0d want 0/1/0", move_valid, busy, moves_left); end
    endtask

    task automatic test_hold;
        int bad;
        bad = 0;
        key_instruction = 4'd1;
        key_write = 1'b1;
        repeat (5) begin
            tick;
            if (move_valid || !busy) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_ignore got %0d bad cycles want 0", bad); end
        key_write = 1'b0;
        scramble = 1'b0;
        tick;
        checks++; if (busy !== 1'b0 || move_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release got busy=%0d valid=%0d want 0/0", busy, move_valid); end
        tick;
    endtask

    task automatic test_reset_mid;
        int n, cyc;
        logic [3:0] d [3];
        n = 0; cyc = 0;
        d[0] = 4'd0; d[1] = 4'd0; d[2] = 4'd0;
        move_ready = 1'b1;
        scramble = 1'b1;
        while (n < 10 && cyc < 100) begin
            tick;
            cyc++;
            if (move_valid) n++;
        end
        checks++; if (n != 10) begin errors++; $display("FAIL mid_reach got %0d want 10", n); end
        reset = 1'b1;
        tick;
        checks++; if (move_valid !== 1'b0 || moves_left !== 8'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset got valid=%0d ml=%0d busy=%0d want 0/0/0", move_valid, moves_left, busy); end
        reset = 1'b0;
        tick;
        tick;
        checks++; if (busy !== 1'b0 || move_valid !== 1'b0) begin
            errors++; $display("FAIL mid_held_scramble got busy=%0d valid=%0d want 0/0", busy, move_valid); end
        scramble = 1'b0;
        tick;
        scramble = 1'b1;
        n = 0; cyc = 0;
        while (n < 3 && cyc < 20) begin
            tick;
            cyc++;
            if (move_valid) begin d[n] = move_dir; n++; end
        end
        checks++; if (d[0] !== 4'd2 || d[1] !== 4'd1 || d[2] !== 4'd1) begin
            errors++; $display("FAIL mid_replay got %0d %0d %0d want 2 1 1", d[0], d[1], d[2]); end
        reset = 1'b1;
        scramble = 1'b0;
        tick;
        reset = 1'b0;
        tick;
    endtask

    initial begin
        reset = 1'b1;
        key_write = 1'b0;
        key_instruction = 4'd0;
        scramble = 1'b0;
        move_ready = 1'b0;
        b_key_write = 1'b0;
        b_key_instruction = 4'd0;
        b_scramble = 1'b0;
        b_move_ready = 1'b0;
        test_reset;
        test_anti_reversal;
        test_key_press;
        test_backpressure;
        test_scramble;
        test_hold;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/f3_move_sched.md
F3_MOVE_SCHED -- requirements
Module: f3_move_sched

Interface
REQ-001 Parameter SCRAMBLE_MOVES, default 8'd64: number of moves issued per scramble; 0 disables scrambling.
REQ-002 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; a seed of 0 SHALL be replaced by 16'h0001.
REQ-003 sysclk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 key_write  in  1  level, high while a direction key is held.
REQ-006 key_instruction  in  4  move code: 1=North, 2=East, 3=West, 4=South; all other values are invalid.
REQ-007 scramble  in  1  level scramble request.
REQ-008 move_ready  in  1  board accepts the move this cycle.
REQ-009 move_valid  out  1  move offered to the board.
REQ-010 move_dir  out  4  direction of the offered move, same coding as key_instruction.
REQ-011 busy  out  1  high while scrambling or waiting for scramble release.
REQ-012 moves_left  out  8  scramble moves not yet transferred; 0 outside SCRAMBLE.

Function
REQ-013 FSM states: IDLE, USER_MOVE, RELEASE, SCRAMBLE, SCR_GAP, SCR_HOLD.
REQ-014 Transfer: a cycle with move_valid=1 and move_ready=1; move_dir SHALL hold stable while move_valid=1 and move_ready=0.
REQ-015 scramble_prev: registered copy of scramble; scramble edge = scramble & ~scramble_prev.
REQ-016 IDLE, scramble edge, SCRAMBLE_MOVES>0: go to SCRAMBLE, moves_left<=SCRAMBLE_MOVES, busy=1; takes priority over a same-cycle key.
REQ-017 IDLE, scramble edge, SCRAMBLE_MOVES=0: go to SCR_HOLD.
REQ-018 IDLE, key_write=1, key_instruction in 1..4, no scramble edge: latch code into move_dir, go to USER_MOVE; move_valid=1 from the next cycle (1-cycle latency).
REQ-019 IDLE, key_write=1 with an invalid code: ignored, stay in IDLE.
REQ-020 USER_MOVE: hold move_valid until transfer; on transfer go to RELEASE with move_valid=0 the next cycle.
REQ-021 RELEASE: stay until key_write=0, then IDLE; exactly one move per key press.
REQ-022 SCRAMBLE: move_valid=1; move_dir = lfsr[1:0]+1 unless that is the opposite of last_dir (1<->4, 2<->3), in which case move_dir = (lfsr[1:0]+1) mod 4 + 1.
REQ-023 LFSR: 16-bit Galois, right shift; if bit0=1 then next = (lfsr>>1)^16'hB400, else next = lfsr>>1; advances only on a scramble transfer.
REQ-024 Scramble transfer: moves_left decrements; if the new value is 0, go to SCR_HOLD, else go to SCR_GAP.
REQ-025 SCR_GAP: move_valid=0 for exactly one cycle, then SCRAMBLE.
REQ-026 SCR_HOLD: busy=1; stay until scramble=0, then IDLE.
REQ-027 key_write and key_instruction SHALL be ignored in SCRAMBLE, SCR_GAP and SCR_HOLD.
REQ-028 last_dir (4 bits) SHALL update to move_dir on every transfer (user or scramble).
REQ-029 busy=1 exactly in SCRAMBLE, SCR_GAP and SCR_HOLD.

Reset
REQ-030 reset=1 at a sysclk edge, in any state including mid-transfer, SHALL set:
- state=IDLE
- move_valid=0, move_dir=0, busy=0, moves_left=0
- last_dir=0
- lfsr=LFSR_SEED (0 replaced by 1)
- scramble_prev=1, so a scramble held through reset starts no scramble.
REQ-031 An offered move that has not transferred when reset is applied SHALL be dropped, not replayed.

Verification
REQ-032 Key press: key_write=1, key_instruction=3, move_ready=1 -> move_valid=1, move_dir=3 for exactly one cycle; no further move until key_write=0 then 1 again.
REQ-033 Backpressure: key 2 with move_ready=0 for 5 cycles -> move_valid=1, move_dir=2 held for 6 cycles; single transfer.
REQ-034 Scramble with default seed, move_ready=1 -> first three move_dir values 2, 1, 1; a one-cycle valid gap between moves; 64 transfers total; moves_left steps 64 down to 0.
REQ-035 Anti-reversal: last_dir=1 and lfsr[1:0]=2'b11 -> move_dir=1, not 4.
REQ-036 Scramble held high after completion -> busy=1 and no moves until scramble=0; keys pressed meanwhile are ignored.
REQ-037 Reset asserted at the 10th scramble move -> next cycle: move_valid=0, moves_left=0, busy=0; a fresh scramble edge replays the sequence 2, 1, 1.
